// File: rtl/demux_deserializer.sv
// ---------------------------------------------------------------------------
// demux_deserializer
//
// Receive-side time-division demultiplexer. Samples arrive one per valid
// cycle and are steered into slots 0..N-1 (N = 2**SELECT_LINES) of a shadow
// word. When slot N-1 is filled, the complete word is registered onto `out`.
// At the same time `out_valid` pulses for one cycle. `sync_out` accompanies
// that pulse when the word's slot 0 was marked by `sync_in`.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (highest priority)
//   in         in   DATA_WIDTH-bit serial sample
//   in_valid   in   sample on `in` is accepted this cycle
//   sync_in    in   frame marker; a qualified sample goes to slot 0
//   out        out  assembled word, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  one-cycle strobe when `out` holds a new complete word
//   sync_out   out  high with out_valid when the word began with sync_in
//   select     out  slot that the next accepted sample will fill
// ---------------------------------------------------------------------------
module demux_deserializer #(
  parameter int SELECT_LINES = 2,
  parameter int DATA_WIDTH   = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [DATA_WIDTH-1:0]                      in,
  input  logic                                       in_valid,
  input  logic                                       sync_in,
  output logic [(1<<SELECT_LINES)*DATA_WIDTH-1:0]    out,
  output logic                                       out_valid,
  output logic                                       sync_out,
  output logic [SELECT_LINES-1:0]                    select
);

  localparam int N  = 1 << SELECT_LINES;
  localparam int WW = N * DATA_WIDTH;

  localparam logic [SELECT_LINES-1:0] LAST_SLOT = SELECT_LINES'(N - 1);
  localparam logic [SELECT_LINES-1:0] ONE_SLOT  = SELECT_LINES'(1);
  // Slot that follows a sync sample: slot 1, or slot 0 again for a one-slot word.
  localparam logic [SELECT_LINES-1:0] SYNC_NEXT = (N == 1) ? SELECT_LINES'(0) : ONE_SLOT;

  logic [SELECT_LINES-1:0] sel_q, sel_d;
  logic [WW-1:0]           shadow_q, shadow_d;
  logic                    flag_q, flag_d;
  logic [WW-1:0]           out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sync_out_q, sync_out_d;

  logic [SELECT_LINES-1:0] slot_s;
  logic [WW-1:0]           merged_s;

  // Next-state logic: slot steering, word completion and frame-sync tracking.
  always_comb begin
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    flag_d      = flag_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_out_d  = 1'b0;

    // A sync sample always restarts the word at slot 0.
    if (sync_in) begin
      slot_s = SELECT_LINES'(0);
    end else begin
      slot_s = sel_q;
    end

    // Shadow word with the current sample merged in. Completion uses this
    // merged value so that the last sample appears on `out` one cycle later.
    merged_s = shadow_q;
    merged_s[int'(slot_s) * DATA_WIDTH +: DATA_WIDTH] = in;

    if (in_valid) begin
      shadow_d = merged_s;

      if (sync_in) begin
        sel_d  = SYNC_NEXT;
        flag_d = 1'b1;
      end else if (sel_q == LAST_SLOT) begin
        sel_d  = SELECT_LINES'(0);
      end else begin
        sel_d  = sel_q + ONE_SLOT;
      end

      if (slot_s == LAST_SLOT) begin
        out_d       = merged_s;
        out_valid_d = 1'b1;
        // sync_in only matters here for a one-slot word, where the sync
        // sample is also the last sample.
        sync_out_d  = flag_q | sync_in;
        flag_d      = 1'b0;
      end else begin
        out_d       = out_q;
      end
    end else if (sync_in) begin
      // Unqualified frame marker: drop the partial word without writing.
      // Its sync flag goes with it, because the next word starts unsynced.
      sel_d  = SELECT_LINES'(0);
      flag_d = 1'b0;
    end else begin
      sel_d  = sel_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= SELECT_LINES'(0);
      shadow_q    <= WW'(0);
      flag_q      <= 1'b0;
      out_q       <= WW'(0);
      out_valid_q <= 1'b0;
      sync_out_q  <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      flag_q      <= flag_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sync_out  = sync_out_q;
  assign select    = sel_q;

  demux_deserializer_chk #(
    .SELECT_LINES (SELECT_LINES)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid_q),
    .sync_out  (sync_out_q)
  );

endmodule

// ---------------------------------------------------------------------------
// demux_deserializer_chk
//
// Protocol properties of the deserialiser outputs.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous reset
//   out_valid  in   word strobe
//   sync_out   in   frame-sync strobe
// ---------------------------------------------------------------------------
module demux_deserializer_chk #(
  parameter int SELECT_LINES = 2
) (
  input logic clk,
  input logic rst,
  input logic out_valid,
  input logic sync_out
);

  // sync_out is only meaningful alongside a word strobe.
  a_sync_with_valid : assert property (@(posedge clk) disable iff (rst)
    sync_out |-> out_valid);

  // With two or more slots a word needs at least two accepted samples, so
  // the strobe can never be high on two consecutive cycles.
  if (SELECT_LINES >= 1) begin : g_pulse
    a_valid_single : assert property (@(posedge clk) disable iff (rst)
      out_valid |=> !out_valid);
  end

endmodule

// File: tb/tb_demux_deserializer.sv
// ---------------------------------------------------------------------------
// tb_demux_deserializer
//
// Two instances share one clock and reset. u_dut0 uses 4 slots of 1 bit, and
// u_dut1 uses 8 slots of 8 bits. Each cycle, the bench updates a sample-list
// reference model for both instances. It then compares out, out_valid,
// sync_out and select against that model. Some directed sequences also
// compare against literal expected words.
// ---------------------------------------------------------------------------
module tb_demux_deserializer;

  logic        clk;
  logic        rst;
  logic [0:0]  in0;
  logic        in_valid0, sync_in0;
  logic [3:0]  out0;
  logic        out_valid0, sync_out0;
  logic [1:0]  select0;
  logic [7:0]  in1;
  logic        in_valid1, sync_in1;
  logic [63:0] out1;
  logic        out_valid1, sync_out1;
  logic [2:0]  select1;

  int n_checks;
  int n_errors;

  // Reference model: samples collected for the current word, per instance.
  logic [7:0]  sbuf [2][8];
  int          cnt [2];
  logic        flag [2];
  logic [63:0] exp_out [2];
  logic        exp_ov [2];
  logic        exp_so [2];

  demux_deserializer #(.SELECT_LINES(2), .DATA_WIDTH(1)) u_dut0 (
    .clk(clk), .rst(rst), .in(in0), .in_valid(in_valid0), .sync_in(sync_in0),
    .out(out0), .out_valid(out_valid0), .sync_out(sync_out0), .select(select0)
  );

  demux_deserializer #(.SELECT_LINES(3), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(in_valid1), .sync_in(sync_in1),
    .out(out1), .out_valid(out_valid1), .sync_out(sync_out1), .select(select1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model for instance `inst`.
  task automatic model_step(input int inst, input logic r, input logic v,
                            input logic s, input logic [7:0] din);
    int n;
    int dw;
    logic [63:0] word;
    n  = (inst == 0) ? 4 : 8;
    dw = (inst == 0) ? 1 : 8;
    exp_ov[inst] = 1'b0;
    exp_so[inst] = 1'b0;
    if (r) begin
      cnt[inst]     = 0;
      flag[inst]    = 1'b0;
      exp_out[inst] = 64'd0;
    end else if (v) begin
      if (s) begin
        cnt[inst]  = 0;
        flag[inst] = 1'b1;
      end
      sbuf[inst][cnt[inst]] = (dw == 1) ? {7'd0, din[0]} : din;
      cnt[inst] = cnt[inst] + 1;
      if (cnt[inst] == n) begin
        word = 64'd0;
        for (int k = 0; k < n; k++) begin
          word = word | (64'(sbuf[inst][k]) << (k * dw));
        end
        exp_out[inst] = word;
        exp_ov[inst]  = 1'b1;
        exp_so[inst]  = flag[inst];
        flag[inst]    = 1'b0;
        cnt[inst]     = 0;
      end
    end else if (s) begin
      cnt[inst]  = 0;
      flag[inst] = 1'b0;
    end
  endtask

  // Drive one cycle on both instances, advance the model and compare outputs.
  task automatic cycle(input logic r,
                       input logic v0, input logic s0, input logic [7:0] d0,
                       input logic v1, input logic s1, input logic [7:0] d1);
    rst       = r;
    in_valid0 = v0;
    sync_in0  = s0;
    in0       = d0[0];
    in_valid1 = v1;
    sync_in1  = s1;
    in1       = d1;
    @(posedge clk);
    model_step(0, r, v0, s0, d0);
    model_step(1, r, v1, s1, d1);
    #1;
    check_eq("out0",       64'(out0),       exp_out[0]);
    check_eq("out_valid0", 64'(out_valid0), 64'(exp_ov[0]));
    check_eq("sync_out0",  64'(sync_out0),  64'(exp_so[0]));
    check_eq("select0",    64'(select0),    64'(cnt[0]));
    check_eq("out1",       out1,            exp_out[1]);
    check_eq("out_valid1", 64'(out_valid1), 64'(exp_ov[1]));
    check_eq("sync_out1",  64'(sync_out1),  64'(exp_so[1]));
    check_eq("select1",    64'(select1),    64'(cnt[1]));
  endtask

  // Instance 0 only; instance 1 is idle.
  task automatic c0(input logic v, input logic s, input logic [7:0] d);
    cycle(1'b0, v, s, d, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    logic [3:0] t2_word;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 2; i++) begin
      cnt[i]     = 0;
      flag[i]    = 1'b0;
      exp_out[i] = 64'd0;
      exp_ov[i]  = 1'b0;
      exp_so[i]  = 1'b0;
    end

    // Reset for three cycles, then release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    c0(1'b0, 1'b0, 8'd0);
    check_eq("rst_out0", 64'(out0), 64'd0);
    check_eq("rst_sel0", 64'(select0), 64'd0);

    // Samples 0,1,0,0 with sync on the first.
    c0(1'b1, 1'b1, 8'd0);
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd0);
    c0(1'b1, 1'b0, 8'd0);
    check_eq("t2_out", 64'(out0), 64'h2);
    check_eq("t2_sync", 64'(sync_out0), 64'd1);
    t2_word = out0;
    check_eq("t2_mux", 64'(t2_word[1]), 64'd1);
    c0(1'b0, 1'b0, 8'd0);
    check_eq("t2_pulse", 64'(out_valid0), 64'd0);

    // Samples 1,0,1,1 with two bubbles between the second and third.
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd0);
    c0(1'b0, 1'b0, 8'd0);
    c0(1'b0, 1'b0, 8'd0);
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd1);
    check_eq("t3_out", 64'(out0), 64'hD);
    check_eq("t3_sync", 64'(sync_out0), 64'd0);

    // Partial word dropped by a sync sample, then a full word of ones.
    c0(1'b1, 1'b0, 8'd0);
    c0(1'b1, 1'b0, 8'd0);
    c0(1'b1, 1'b1, 8'd1);
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd1);
    check_eq("t4_out", 64'(out0), 64'hF);
    check_eq("t4_sync", 64'(sync_out0), 64'd1);

    // Reset in the middle of a word, then samples 1,0,0,0.
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    c0(1'b1, 1'b0, 8'd1);
    c0(1'b1, 1'b0, 8'd0);
    c0(1'b1, 1'b0, 8'd0);
    c0(1'b1, 1'b0, 8'd0);
    check_eq("t5_out", 64'(out0), 64'h1);
    check_eq("t5_sync", 64'(sync_out0), 64'd0);

    // 8 slots of 8 bits: 16 contiguous samples 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'(i));
      if (i == 7) begin
        check_eq("t6_word0", out1, 64'h0706050403020100);
        check_eq("t6_valid0", 64'(out_valid1), 64'd1);
      end
      if (i == 15) begin
        check_eq("t6_word1", out1, 64'h0F0E0D0C0B0A0908);
        check_eq("t6_valid1", 64'(out_valid1), 64'd1);
      end
    end

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            8'($urandom),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
